// File: rtl/game_state_ctrl_if.sv
// UART link bundle between the game sequencer and the UART core.
// master: sequencer side (consumes RX, drives TX requests); slave: UART side.
interface game_state_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_busy,
        output tx_data,
        output tx_start
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_busy,
        input  tx_data,
        input  tx_start
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: MENU/READY/GAME/SCORE state, two-player UART sync, hit scoring.
// Optional macro GAME_PAUSE_EN adds a PAUSE state toggled by the start button during GAME.
module game_state_ctrl #(
    parameter int unsigned READY_CYCLES = 32'd300000000,
    parameter int unsigned SCORE_HOLD   = 32'd1000000000,
    parameter logic [7:0]  READY_BYTE   = 8'h52
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_btn,
    input  logic                     hit,
    input  logic                     end_of_time,
    game_state_ctrl_if.master        uart,
    output logic [1:0]               state_out,
    output logic                     timer_rst,
    output logic [7:0]               score,
    output logic [7:0]               remote_score,
    output logic                     remote_valid
);

    localparam logic [1:0]  CODE_MENU  = 2'b00;
    localparam logic [1:0]  CODE_READY = 2'b01;
    localparam logic [1:0]  CODE_GAME  = 2'b10;
    localparam logic [1:0]  CODE_SCORE = 2'b11;
    localparam logic [31:0] READY_LOAD = READY_CYCLES - 32'd1;
    localparam logic [31:0] SCORE_LAST = SCORE_HOLD - 32'd1;

`ifdef GAME_PAUSE_EN
    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_READY = 3'd1,
        ST_GAME  = 3'd2,
        ST_SCORE = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_READY = 2'd1,
        ST_GAME  = 2'd2,
        ST_SCORE = 2'd3
    } state_t;
`endif

    state_t      state_r;
    logic        start_q_r;
    logic        local_rdy_r;
    logic        remote_rdy_r;
    logic [31:0] cnt_r;
    logic        pend_r;
    logic [7:0]  pend_byte_r;
    logic [7:0]  tx_data_r;
    logic        tx_start_r;

    logic        start_edge_s;
    logic        rx_ready_s;
    logic        local_next_s;
    logic        remote_next_s;
    logic        pause_edge_s;
    logic [7:0]  score_hit_s;
    logic        req_s;
    logic [7:0]  req_byte_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    assign uart.tx_data  = tx_data_r;
    assign uart.tx_start = tx_start_r;

    // Edge detect, ready-flag lookahead, saturated score and TX request selection.
    always_comb begin
        start_edge_s  = start_btn & ~start_q_r;
        rx_ready_s    = uart.rx_valid & (uart.rx_data == READY_BYTE);
        local_next_s  = local_rdy_r | start_edge_s;
        remote_next_s = remote_rdy_r | rx_ready_s;
`ifdef GAME_PAUSE_EN
        pause_edge_s  = start_edge_s;
`else
        pause_edge_s  = 1'b0;
`endif
        if (hit) begin
            score_hit_s = sat_inc(score);
        end else begin
            score_hit_s = score;
        end
        req_s      = 1'b0;
        req_byte_s = 8'h00;
        case (state_r)
            ST_MENU: begin
                if (start_edge_s && !local_rdy_r) begin
                    req_s      = 1'b1;
                    req_byte_s = READY_BYTE;
                end else begin
                    req_s      = 1'b0;
                    req_byte_s = 8'h00;
                end
            end
            ST_GAME: begin
                // The score byte already includes a hit landing in the same cycle.
                if (!pause_edge_s && end_of_time) begin
                    req_s      = 1'b1;
                    req_byte_s = score_hit_s;
                end else begin
                    req_s      = 1'b0;
                    req_byte_s = 8'h00;
                end
            end
            default: begin
                req_s      = 1'b0;
                req_byte_s = 8'h00;
            end
        endcase
    end

    // Game sequencer FSM with registered state code, timer clear and score registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_MENU;
            state_out    <= CODE_MENU;
            timer_rst    <= 1'b1;
            score        <= 8'h00;
            remote_score <= 8'h00;
            remote_valid <= 1'b0;
            local_rdy_r  <= 1'b0;
            remote_rdy_r <= 1'b0;
            cnt_r        <= 32'd0;
            start_q_r    <= 1'b0;
        end else begin
            start_q_r <= start_btn;
            case (state_r)
                ST_MENU: begin
                    if (local_next_s && remote_next_s) begin
                        state_r      <= ST_READY;
                        state_out    <= CODE_READY;
                        timer_rst    <= 1'b0;
                        score        <= 8'h00;
                        remote_score <= 8'h00;
                        remote_valid <= 1'b0;
                        local_rdy_r  <= 1'b0;
                        remote_rdy_r <= 1'b0;
                        cnt_r        <= READY_LOAD;
                    end else begin
                        local_rdy_r  <= local_next_s;
                        remote_rdy_r <= remote_next_s;
                    end
                end
                ST_READY: begin
                    if (cnt_r == 32'd0) begin
                        state_r   <= ST_GAME;
                        state_out <= CODE_GAME;
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                ST_GAME: begin
`ifdef GAME_PAUSE_EN
                    if (start_edge_s) begin
                        state_r   <= ST_PAUSE;
                        state_out <= CODE_READY;
                    end else
`endif
                    begin
                        score <= score_hit_s;
                        if (end_of_time) begin
                            state_r   <= ST_SCORE;
                            state_out <= CODE_SCORE;
                            cnt_r     <= 32'd0;
                        end else begin
                            state_r <= ST_GAME;
                        end
                    end
                end
                ST_SCORE: begin
                    if (uart.rx_valid && !remote_valid) begin
                        remote_score <= uart.rx_data;
                        remote_valid <= 1'b1;
                    end else begin
                        remote_valid <= remote_valid;
                    end
                    if (start_edge_s || (cnt_r == SCORE_LAST)) begin
                        state_r   <= ST_MENU;
                        state_out <= CODE_MENU;
                        timer_rst <= 1'b1;
                        cnt_r     <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
`ifdef GAME_PAUSE_EN
                ST_PAUSE: begin
                    // state_out stays 01 here so the timer holds its count.
                    if (start_edge_s) begin
                        state_r   <= ST_GAME;
                        state_out <= CODE_GAME;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_MENU;
                    state_out <= CODE_MENU;
                    timer_rst <= 1'b1;
                    cnt_r     <= 32'd0;
                end
            endcase
        end
    end

    // One-deep TX request buffer; a new request in the issue cycle refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= 1'b0;
            pend_byte_r <= 8'h00;
            tx_data_r   <= 8'h00;
            tx_start_r  <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            if (pend_r && !uart.tx_busy) begin
                tx_start_r <= 1'b1;
                tx_data_r  <= pend_byte_r;
                pend_r     <= 1'b0;
            end
            if (req_s) begin
                pend_r      <= 1'b1;
                pend_byte_r <= req_byte_s;
            end
        end
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer: owns the 2-bit game state (MENU/READY/GAME/SCORE) consumed by game_timer via state_in and by the render/game logic.
- Clears game_timer between rounds and leaves GAME on end_of_time.
- Synchronises both players over the UART link: ready handshake in MENU, score exchange in SCORE.
- Counts local hits and drives the UART TX with a one-deep pending request.

Parameters:
READY_CYCLES, 300000000, READY-state countdown length in clk cycles (3 s at 100 MHz)
SCORE_HOLD, 1000000000, cycles spent in SCORE before automatic return to MENU (10 s)
READY_BYTE, 8'h52, UART code meaning "player ready"

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
start_btn  in  1  debounced local start button, level
hit  in  1  one-cycle pulse from game logic: local player scored
end_of_time  in  1  from game_timer, level, sticky until timer reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_busy  in  1  UART TX busy
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit strobe
state_out  out  2  00 MENU, 01 READY/PAUSE, 10 GAME, 11 SCORE; to game_timer state_in
timer_rst  out  1  high while in MENU; drives game_timer clear
score  out  8  local hit count
remote_score  out  8  score received from remote player
remote_valid  out  1  remote_score captured this round

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state MENU, so state_out=00 and timer_rst=1.
  - score=0, remote_score=0, remote_valid=0, tx_start=0, tx_data=0.
  - Pending-TX flag, ready flags, counters and start_q all cleared.
- Registers: all outputs are registered, and state_out changes on the clock edge after the triggering input.
- Start edge detection:
  - start_edge = start_btn & ~start_q, where start_q is start_btn registered once.
  - A held button yields exactly one edge.
- MENU:
  - First start_edge sets local_rdy and queues a TX of READY_BYTE.
  - rx_valid with rx_data==READY_BYTE sets remote_rdy. Any other byte is ignored.
  - When local_rdy && remote_rdy (any order, or the same cycle), go to READY.
  - On that transition: clear score, remote_score, remote_valid and both ready flags; load the countdown with READY_CYCLES-1.
- READY:
  - The countdown decrements each cycle; at 0, go to GAME. Exactly READY_CYCLES cycles are spent in READY.
  - start_edge, hit and rx are ignored.
- GAME:
  - hit increments score, saturating at 8'hFF.
  - end_of_time=1 goes to SCORE and queues a TX of the score value including any hit in the same cycle.
  - hit and end_of_time in the same cycle: the hit is counted first.
- SCORE:
  - The first rx_valid latches rx_data into remote_score and sets remote_valid. Later bytes are ignored.
  - The hold counter counts from 0. On start_edge or count==SCORE_HOLD-1, go to MENU.
  - On entering MENU, timer_rst asserts and clears end_of_time in the timer.
- TX request handling:
  - A queued request sets pend with its byte.
  - When pend && !tx_busy: tx_start=1 for one cycle, tx_data=byte, pend cleared.
  - tx_start never asserts while tx_busy=1.
  - A new request while pend=1 overwrites the byte. Protocol guarantees this cannot happen in normal play.
  - Reset drops any pending request.
- timer_rst: timer_rst = (state==MENU), registered with the state.
- Reset mid-operation: any state returns to MENU in one cycle. No TX is issued in that cycle.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - In GAME, start_edge enters an internal PAUSE state: state_out=01, so the timer freezes. hit and end_of_time are ignored.
  - A further start_edge returns to GAME, and the timer resumes from its held count.
  - rst in PAUSE goes to MENU.
- Undefined:
  - start_edge is ignored in GAME.
  - No PAUSE state is synthesised.

Test Plan (READY_CYCLES=10, SCORE_HOLD=20):
1. Reset, then start_btn rising edge, then rx 0x52 five cycles later -> tx_start once with tx_data=0x52; state_out 00->01 one cycle after rx_valid; 01 held exactly 10 cycles, then 10.
2. rx 0x52 first, start edge 3 cycles later, tx_busy=1 for 6 cycles -> tx_start deferred until the first cycle with tx_busy=0; READY entered after the start edge; only one 0x52 sent.
3. In GAME, 300 hit pulses -> score saturates at 8'hFF. Second run: 7 hits, the last coincident with end_of_time -> state 11, tx_data=0x07.
4. In SCORE, rx 0x0C then 0x05 -> remote_score=0x0C, remote_valid=1. No start edge -> MENU after exactly 20 cycles, with timer_rst=1 in the same cycle state_out=00.
5. rst pulsed mid-GAME with pend set and tx_busy=1 -> next cycle state_out=00, score=0, timer_rst=1; no tx_start after tx_busy falls.
6. GAME_PAUSE_EN defined: start edge in GAME -> state_out=01; hit and end_of_time ignored. Second edge -> 10, score unchanged. Undefined: edge has no effect.
